// File: rtl/disp_pkg.sv
// Shared types and helpers for the display datapath (BCD converter and display controller).
package disp_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    // 10**n, evaluated at elaboration for comparator thresholds.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_adj3
    import disp_pkg::*;
(
    input  bcd_t i_nib,
    output bcd_t o_nib_c
);

    assign o_nib_c = (i_nib >= 4'd5) ? bcd_t'(i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional BIN2BCD_SAT_EN: an out-of-range input loads all nines instead of bin mod 10^ND.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int unsigned W  = 14,
    parameter int unsigned ND = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [W-1:0]           bin,
    output logic                   ready,
    output logic                   done,
    output logic [DIGIT_W*ND-1:0]  digits,
    output logic                   overflow
);

    localparam int unsigned DW = DIGIT_W * ND;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [63:0] MAX_V  = pow10(ND) - 64'd1;
    localparam bit          OVF_EN = (W >= 64) || (((64'd1 << W) - 64'd1) > MAX_V);
`ifdef BIN2BCD_SAT_EN
    localparam logic [DW-1:0] NINES = {ND{4'h9}};
`endif

    conv_state_t     r_state;
    logic [W-1:0]    r_sh;
    logic [DW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf_next;
    logic [DW-1:0]   w_adj;
    logic            w_ovf_cmp;

    for (genvar g = 0; g < ND; g++) begin : g_adj
        bcd_adj3 u_adj (
            .i_nib   (r_acc[g*DIGIT_W +: DIGIT_W]),
            .o_nib_c (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Overflow is structurally impossible when every W-bit value fits in ND digits.
    if (OVF_EN) begin : g_ovf
        assign w_ovf_cmp = (64'(bin) > MAX_V);
    end else begin : g_no_ovf
        assign w_ovf_cmp = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sh       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            ready      <= 1'b1;
            done       <= 1'b0;
            digits     <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh       <= bin;
                        r_acc      <= '0;
                        r_cnt      <= CW'(W);
                        r_ovf_next <= w_ovf_cmp;
                        r_state    <= SHIFT;
                        ready      <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Top-nibble carry-out is dropped, giving bin mod 10^ND.
                    r_acc <= {w_adj[DW-2:0], r_sh[W-1]};
                    r_sh  <= {r_sh[W-2:0], 1'b0};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
`ifdef BIN2BCD_SAT_EN
                    digits <= r_ovf_next ? NINES : r_acc;
`else
                    digits <= r_acc;
`endif
                    overflow <= r_ovf_next;
                    done     <= 1'b1;
                    ready    <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (W=14, ND=4).
module tb_bin2bcd_seq;

    localparam int unsigned W   = 14;
    localparam int unsigned ND  = 4;
    localparam int          LAT = 15;
    localparam int          TMO = 60;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  bin = '0;
    logic          ready;
    logic          done;
    logic [15:0]   digits;
    logic          overflow;

    int n_pass = 0;
    int n_tot  = 0;

    bin2bcd_seq #(.W(W), .ND(ND)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bin      (bin),
        .ready    (ready),
        .done     (done),
        .digits   (digits),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] b;
        logic [15:0]  exp_d;
        logic         exp_o;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one start pulse and wait for done; lat counts edges after the accept edge.
    task automatic convert(input logic [W-1:0] b, output int lat, output int rdy_low);
        @(negedge clk);
        start = 1'b1;
        bin   = b;
        cyc();
        start = 1'b0;
        bin   = W'($urandom);
        lat     = 0;
        rdy_low = ready ? 0 : 1;
        while (!done && lat < TMO) begin
            cyc();
            lat++;
            if (!ready) rdy_low++;
        end
    endtask

    vec_t vecs[$];
    int   lat, rlow, ndone, t1, t2;
    logic [15:0] d1, d2;

    initial begin
`ifdef BIN2BCD_SAT_EN
        vecs.push_back('{14'd12345, 16'h9999, 1'b1});
        vecs.push_back('{14'd16383, 16'h9999, 1'b1});
        vecs.push_back('{14'd10000, 16'h9999, 1'b1});
`else
        vecs.push_back('{14'd12345, 16'h2345, 1'b1});
        vecs.push_back('{14'd16383, 16'h6383, 1'b1});
        vecs.push_back('{14'd10000, 16'h0000, 1'b1});
`endif
        vecs.push_back('{14'd1234, 16'h1234, 1'b0});
        vecs.push_back('{14'd0,    16'h0000, 1'b0});
        vecs.push_back('{14'd9999, 16'h9999, 1'b0});
        vecs.push_back('{14'd5,    16'h0005, 1'b0});
        vecs.push_back('{14'd1,    16'h0001, 1'b0});
        vecs.push_back('{14'd10,   16'h0010, 1'b0});
        vecs.push_back('{14'd100,  16'h0100, 1'b0});
        vecs.push_back('{14'd1000, 16'h1000, 1'b0});

        repeat (2) @(negedge clk);
        chk("rst_ready",    32'(ready),    32'd1);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_digits",   32'(digits),   32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        cyc();

        foreach (vecs[i]) begin
            convert(vecs[i].b, lat, rlow);
            chk($sformatf("lat_%0d", vecs[i].b),   32'(lat),      32'(LAT));
            chk($sformatf("rdylo_%0d", vecs[i].b), 32'(rlow),     32'(LAT));
            chk($sformatf("dig_%0d", vecs[i].b),   32'(digits),   32'(vecs[i].exp_d));
            chk($sformatf("ovf_%0d", vecs[i].b),   32'(overflow), 32'(vecs[i].exp_o));
            chk($sformatf("rdy_%0d", vecs[i].b),   32'(ready),    32'd1);
            cyc();
            chk($sformatf("pulse_%0d", vecs[i].b), 32'(done),     32'd0);
            chk($sformatf("hold_%0d", vecs[i].b),  32'(digits),   32'(vecs[i].exp_d));
        end

        // Start while busy is ignored and not queued.
        @(negedge clk);
        start = 1'b1; bin = 14'd4321;
        cyc();
        start = 1'b0;
        lat = 0;
        while (!done && lat < TMO) begin
            cyc();
            lat++;
            if (lat == 5) begin start = 1'b1; bin = 14'd7777; end
            else begin start = 1'b0; end
        end
        start = 1'b0;
        chk("busy_lat",    32'(lat),    32'(LAT));
        chk("busy_digits", 32'(digits), 32'h4321);
        ndone = 0;
        repeat (20) begin cyc(); if (done) ndone++; end
        chk("busy_noqueue", 32'(ndone),  32'd0);
        chk("busy_hold",    32'(digits), 32'h4321);

        // Start held high: back-to-back conversions re-sample bin.
        @(negedge clk);
        start = 1'b1; bin = 14'd42;
        cyc();
        bin = 14'd9001;
        lat = 0; t1 = -1; t2 = -1; d1 = '0; d2 = '0;
        while (t2 < 0 && lat < 2*TMO) begin
            cyc();
            lat++;
            if (done) begin
                if (t1 < 0) begin t1 = lat; d1 = digits; end
                else begin t2 = lat; d2 = digits; end
            end
        end
        start = 1'b0;
        chk("b2b_first_lat", 32'(t1),      32'(LAT));
        chk("b2b_first",     32'(d1),      32'h0042);
        chk("b2b_second",    32'(d2),      32'h9001);
        chk("b2b_gap",       32'(t2 - t1), 32'd16);
        repeat (20) cyc();

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; bin = 14'd1234;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        chk("mid_busy", 32'(ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("arst_digits", 32'(digits), 32'd0);
        chk("arst_ready",  32'(ready),  32'd1);
        chk("arst_done",   32'(done),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        cyc();
        chk("post_rst_ready", 32'(ready), 32'd1);
        repeat (20) begin cyc(); if (done) ndone++; end
        chk("post_rst_nodone", 32'(ndone),    32'd0);
        chk("post_rst_digits", 32'(digits),   32'd0);
        chk("post_rst_ovf",    32'(overflow), 32'd0);

        // Converter still works after the abort.
        convert(14'd1234, lat, rlow);
        chk("after_rst_lat", 32'(lat),    32'(LAT));
        chk("after_rst_dig", 32'(digits), 32'h1234);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
